// File: rtl/echo_pkg.sv
// Shared constants, state encoding and clip limits for the echo-cancellation chain.
package echo_pkg;
    localparam int DATA_W    = 16;
    localparam int COEF_W    = 16;
    localparam int COEF_FRAC = 15;
    localparam int TAPS      = 4;
    localparam int PROD_W    = DATA_W + COEF_W;
    localparam int ACC_W     = DATA_W + COEF_W + 3;

    localparam logic signed [DATA_W-1:0] SAT_MAX = 16'sh7FFF;
    localparam logic signed [DATA_W-1:0] SAT_MIN = 16'sh8000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_SAT  = 2'd2
    } state_t;
endpackage

// File: rtl/echo_round_sat.sv
// Combinational round-half-up of a Q.COEF_FRAC accumulator to a DATA_W sample with clipping.
module echo_round_sat
    import echo_pkg::*;
#(
    parameter int IN_W = ACC_W
) (
    input  logic signed [IN_W-1:0]   acc,
    output logic signed [DATA_W-1:0] result,
    output logic                     clipped
);
    localparam logic signed [IN_W-1:0] HALF  = IN_W'(1) << (COEF_FRAC - 1);
    localparam logic signed [IN_W-1:0] MAX_W = IN_W'(SAT_MAX);
    localparam logic signed [IN_W-1:0] MIN_W = IN_W'(SAT_MIN);

    logic signed [IN_W-1:0] rounded;
    logic signed [IN_W-1:0] shifted;

    always_comb begin
        rounded = acc + HALF;
        shifted = rounded >>> COEF_FRAC;
        result  = shifted[DATA_W-1:0];
        clipped = 1'b0;
        if (shifted > MAX_W) begin
            result  = SAT_MAX;
            clipped = 1'b1;
        end else if (shifted < MIN_W) begin
            result  = SAT_MIN;
            clipped = 1'b1;
        end
    end
endmodule

// File: rtl/echo_deconvolver_16b.sv
// IIR inverse of the 4-tap echo model: x[n] = y[n] - sum a_k*x[n-1-k], one shared MAC.
module echo_deconvolver_16b
    import echo_pkg::*;
(
    input  logic                     clk_operation,
    input  logic                     rst,
    input  logic                     enable,
    input  logic signed [DATA_W-1:0] sig16b_echo,
    input  logic signed [COEF_W-1:0] para_0,
    input  logic signed [COEF_W-1:0] para_1,
    input  logic signed [COEF_W-1:0] para_2,
    input  logic signed [COEF_W-1:0] para_3,
    output logic signed [DATA_W-1:0] sig16b_clean,
    output logic                     ready,
    output logic                     busy,
    output logic                     sat
);
    state_t                    state_q, state_d;
    logic                      en_prev_q, en_prev_d;
    logic [1:0]                k_q, k_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic signed [COEF_W-1:0]  coef_q [TAPS];
    logic signed [COEF_W-1:0]  coef_d [TAPS];
    logic signed [DATA_W-1:0]  hist_q [TAPS];
    logic signed [DATA_W-1:0]  hist_d [TAPS];
    logic signed [DATA_W-1:0]  clean_q, clean_d;
    logic                      ready_q, ready_d;
    logic                      busy_q, busy_d;
    logic                      sat_q, sat_d;

    logic signed [COEF_W-1:0]  para_in [TAPS];
    logic signed [PROD_W-1:0]  prod;
    logic signed [DATA_W-1:0]  rs_result;
    logic                      rs_clip;
    logic                      start;

    assign para_in[0] = para_0;
    assign para_in[1] = para_1;
    assign para_in[2] = para_2;
    assign para_in[3] = para_3;

    assign prod  = PROD_W'(coef_q[k_q]) * PROD_W'(hist_q[k_q]);
    assign start = enable && !en_prev_q && (state_q == ST_IDLE);

    echo_round_sat #(.IN_W(ACC_W)) u_round_sat (
        .acc     (acc_q),
        .result  (rs_result),
        .clipped (rs_clip)
    );

    always_comb begin
        state_d   = state_q;
        en_prev_d = enable;
        k_d       = k_q;
        acc_d     = acc_q;
        coef_d    = coef_q;
        hist_d    = hist_q;
        clean_d   = clean_q;
        ready_d   = ready_q;
        busy_d    = busy_q;
        sat_d     = sat_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    coef_d  = para_in;
                    acc_d   = ACC_W'(sig16b_echo) <<< COEF_FRAC;
                    k_d     = 2'd0;
                    busy_d  = 1'b1;
                    ready_d = 1'b0;
                    state_d = ST_MAC;
                end
            end
            ST_MAC: begin
                acc_d = acc_q - ACC_W'(prod);
                k_d   = k_q + 2'd1;
                if (k_q == 2'(TAPS - 1)) begin
                    state_d = ST_SAT;
                end
            end
            ST_SAT: begin
                // History keeps the clipped value so the filter sees what was emitted.
                clean_d = rs_result;
                sat_d   = rs_clip;
                for (int i = TAPS - 1; i > 0; i--) begin
                    hist_d[i] = hist_q[i-1];
                end
                hist_d[0] = rs_result;
                ready_d   = 1'b1;
                busy_d    = 1'b0;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_operation) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            en_prev_q <= 1'b0;
            k_q       <= 2'd0;
            acc_q     <= '0;
            clean_q   <= '0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            sat_q     <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                coef_q[i] <= '0;
                hist_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            en_prev_q <= en_prev_d;
            k_q       <= k_d;
            acc_q     <= acc_d;
            clean_q   <= clean_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            sat_q     <= sat_d;
            coef_q    <= coef_d;
            hist_q    <= hist_d;
        end
    end

    assign sig16b_clean = clean_q;
    assign ready        = ready_q;
    assign busy         = busy_q;
    assign sat          = sat_q;
endmodule

// File: tb/tb_echo_deconvolver_16b.sv
// Directed self-checking bench for echo_deconvolver_16b, including a bench-modelled echo round trip.
module tb_echo_deconvolver_16b;
    logic               clk_operation;
    logic               rst;
    logic               enable;
    logic signed [15:0] sig16b_echo;
    logic signed [15:0] para_0, para_1, para_2, para_3;
    logic signed [15:0] sig16b_clean;
    logic               ready, busy, sat;

    int n_assert = 0;
    int n_fail   = 0;

    echo_deconvolver_16b dut (
        .clk_operation (clk_operation),
        .rst           (rst),
        .enable        (enable),
        .sig16b_echo   (sig16b_echo),
        .para_0        (para_0),
        .para_1        (para_1),
        .para_2        (para_2),
        .para_3        (para_3),
        .sig16b_clean  (sig16b_clean),
        .ready         (ready),
        .busy          (busy),
        .sat           (sat)
    );

    initial clk_operation = 1'b0;
    always #5 clk_operation = ~clk_operation;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
        $display("check %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk_operation);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    // Issues one start pulse and waits for ready; lat = edges from start edge to ready.
    task automatic run_sample(input logic signed [15:0] y, input logic signed [15:0] c0,
                              input logic signed [15:0] c1, input logic signed [15:0] c2,
                              input logic signed [15:0] c3, output int lat);
        sig16b_echo = y;
        para_0 = c0; para_1 = c1; para_2 = c2; para_3 = c3;
        enable = 1'b1;
        tick();
        enable = 1'b0;
        lat = 0;
        while (ready !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        if (ready !== 1'b1) check("ready_timeout", ready, 1);
    endtask

    logic signed [15:0] vec_y   [4] = '{16'sd100, -16'sd5, 16'sd32767, -16'sd32768};
    logic signed [15:0] imp_y   [4] = '{16'sd16384, 16'sd0, 16'sd0, 16'sd0};
    logic signed [15:0] imp_x   [4] = '{16'sd16384, -16'sd8192, 16'sd4096, -16'sd2048};
    logic signed [15:0] sat_y   [3] = '{16'sd32767, 16'sd32767, 16'sd0};
    logic signed [15:0] sat_x   [3] = '{16'sd32767, 16'sd32767, 16'sd32767};
    logic               sat_f   [3] = '{1'b0, 1'b1, 1'b0};

    initial begin
        int lat;
        int rises;
        logic prev_busy;
        longint xs [4];
        longint a  [4];
        longint x, s, yv, d;

        rst = 1'b0; enable = 1'b0; sig16b_echo = '0;
        para_0 = '0; para_1 = '0; para_2 = '0; para_3 = '0;
        repeat (3) tick();
        check("rst_clean", sig16b_clean, 0);
        check("rst_ready", ready, 0);
        check("rst_busy", busy, 0);
        check("rst_sat", sat, 0);
        rst = 1'b1;
        tick();

        // Pass-through with zero coefficients
        for (int i = 0; i < 4; i++) begin
            run_sample(vec_y[i], 16'sd0, 16'sd0, 16'sd0, 16'sd0, lat);
            check("pass_x", sig16b_clean, vec_y[i]);
            check("pass_sat", sat, 0);
            check("pass_lat", lat, 5);
            check("pass_busy", busy, 0);
        end

        // Impulse response with a_0 = +0.5
        do_reset();
        for (int i = 0; i < 4; i++) begin
            run_sample(imp_y[i], 16'sh4000, 16'sd0, 16'sd0, 16'sd0, lat);
            check("impulse_x", sig16b_clean, imp_x[i]);
            check("impulse_sat", sat, 0);
        end

        // Saturation with a_0 = -1.0
        do_reset();
        for (int i = 0; i < 3; i++) begin
            run_sample(sat_y[i], 16'sh8000, 16'sd0, 16'sd0, 16'sd0, lat);
            check("satur_x", sig16b_clean, sat_x[i]);
            check("satur_flag", sat, sat_f[i]);
        end

        // Busy guard: second pulse at E+2 must be ignored
        sig16b_echo = 16'sd123;
        para_0 = '0; para_1 = '0; para_2 = '0; para_3 = '0;
        enable = 1'b1;
        tick();
        check("guard_busy_e", busy, 1);
        check("guard_ready_e", ready, 0);
        enable = 1'b0;
        tick();
        enable = 1'b1;
        tick();
        enable = 1'b0;
        tick();
        tick();
        check("guard_not_ready_e4", ready, 0);
        tick();
        check("guard_ready_e5", ready, 1);
        check("guard_x", sig16b_clean, 123);
        rises = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (busy === 1'b1) rises++;
        end
        check("guard_no_second", rises, 0);
        check("guard_ready_held", ready, 1);

        // Enable held high for 10 clocks yields one sample
        sig16b_echo = 16'sd55;
        enable = 1'b1;
        prev_busy = 1'b0;
        rises = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (busy === 1'b1 && prev_busy === 1'b0) rises++;
            prev_busy = busy;
        end
        enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (busy === 1'b1 && prev_busy === 1'b0) rises++;
            prev_busy = busy;
        end
        check("held_one_sample", rises, 1);
        check("held_x", sig16b_clean, 55);

        // Reset in the middle of the MAC phase
        sig16b_echo = 16'sd1000;
        para_0 = 16'sh4000; para_1 = 16'sh4000; para_2 = 16'sh4000; para_3 = 16'sh4000;
        enable = 1'b1;
        tick();
        enable = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("abort_clean", sig16b_clean, 0);
        check("abort_ready", ready, 0);
        check("abort_busy", busy, 0);
        check("abort_sat", sat, 0);
        rst = 1'b1;
        run_sample(16'sd7, 16'sh4000, 16'sh4000, 16'sh4000, 16'sh4000, lat);
        check("abort_hist_cleared", sig16b_clean, 7);
        run_sample(16'sd7, 16'sd0, 16'sd0, 16'sd0, 16'sd0, lat);
        check("abort_next_x", sig16b_clean, 7);

        // Round trip through the echo model
        do_reset();
        for (int k = 0; k < 4; k++) begin
            xs[k] = 0;
            a[k]  = longint'($urandom_range(8192, 0)) - 4096;
        end
        for (int n = 0; n < 256; n++) begin
            x = longint'($urandom_range(15998, 0)) - 7999;
            s = 0;
            for (int k = 0; k < 4; k++) s += a[k] * xs[k];
            yv = x + ((s + 16384) >>> 15);
            run_sample(16'(yv), 16'(a[0]), 16'(a[1]), 16'(a[2]), 16'(a[3]), lat);
            d = longint'(sig16b_clean) - x;
            n_assert++;
            assert (d >= -1 && d <= 1) else begin
                n_fail++;
                $error("FAIL roundtrip n=%0d observed=%0d expected=%0d+-1", n, sig16b_clean, x);
            end
            $display("roundtrip n=%0d y=%0d observed=%0d expected=%0d", n, yv, sig16b_clean, x);
            for (int k = 3; k > 0; k--) xs[k] = xs[k-1];
            xs[0] = x;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
